// File: rtl/mul_8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_8_pkg
// Purpose  : Shared constants for the 8x8 shift-and-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mul_8_pkg;

  localparam int MUL_W    = 8;
  localparam int MUL_ITER = 8;
  localparam int CNT_W    = $clog2(MUL_ITER);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/adder_8.sv
`default_nettype none
// ============================================================================
// Module   : adder_8
// Purpose  : 8-bit Kogge-Stone prefix adder, carry-in 0, no carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);

  always_comb begin
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [7:0] w_g_n;
    logic [7:0] w_p_n;
    w_g   = a & b;
    w_p   = a ^ b;
    w_g_n = w_g;
    w_p_n = w_p;
    // Three prefix levels (span 1, 2, 4) resolve the group generate of every bit.
    for (int k = 0; k < 3; k++) begin
      w_g_n = w_g;
      w_p_n = w_p;
      for (int i = (1 << k); i < 8; i++) begin
        w_g_n[i] = w_g[i] | (w_p[i] & w_g[i - (1 << k)]);
        w_p_n[i] = w_p[i] & w_p[i - (1 << k)];
      end
      w_g = w_g_n;
      w_p = w_p_n;
    end
    s = (a ^ b) ^ {w_g[6:0], 1'b0};
  end

endmodule
`default_nettype wire

// File: rtl/mul_8.sv
`default_nettype none
// ============================================================================
// Module   : mul_8
// Purpose  : Sequential 8x8 unsigned shift-and-add multiplier, one adder pass
//            per cycle, 9-cycle start-to-done latency.
// Revision : 1.0 - initial release
// ============================================================================
module mul_8
  import mul_8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(MUL_ITER - 1);

  state_t               r_state;
  logic [MUL_W-1:0]     r_m;
  logic [MUL_W-1:0]     r_acc;
  logic [MUL_W-1:0]     r_q;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*MUL_W-1:0]   r_product;

  logic [MUL_W-1:0]     w_sum;
  logic                 w_carry;
  logic [MUL_W-1:0]     w_acc_nxt;
  logic [MUL_W-1:0]     w_q_nxt;

  adder_8 u_adder (
    .a (r_acc),
    .b (r_m),
    .s (w_sum)
  );

  // The adder has no carry-out; recover it from the operand and sum MSBs.
  assign w_carry = (r_acc[MUL_W-1] & r_m[MUL_W-1]) |
                   ((r_acc[MUL_W-1] | r_m[MUL_W-1]) & ~w_sum[MUL_W-1]);

  always_comb begin
    w_acc_nxt = {1'b0, r_acc[MUL_W-1:1]};
    w_q_nxt   = {r_acc[0], r_q[MUL_W-1:1]};
    if (r_q[0]) begin
      w_acc_nxt = {w_carry, w_sum[MUL_W-1:1]};
      w_q_nxt   = {w_sum[0], r_q[MUL_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_product <= {w_acc_nxt, w_q_nxt};
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mul_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_8
// Purpose  : Self-checking bench for mul_8 with an expected-product queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_prod = 16'h0000;

  mul_8 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h exp 0000", product); end
    last_prod = 16'h0000;
  endtask

  task automatic test_products();
    logic [7:0]  ta [0:3];
    logic [7:0]  tb [0:3];
    logic [15:0] exp;
    ta = '{8'h0F, 8'hFF, 8'h00, 8'h5A};
    tb = '{8'h0F, 8'hFF, 8'h5A, 8'h00};
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; a = ta[i]; b = tb[i];
      exp_q.push_back(16'(ta[i]) * 16'(tb[i]));
      for (int c = 1; c <= 10; c++) begin
        tick();
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        checks++;
        if (busy !== (c <= 9)) begin errors++; $display("FAIL prod%0d_busy c=%0d got %b exp %b", i, c, busy, (c <= 9)); end
        checks++;
        if (done !== (c == 9)) begin errors++; $display("FAIL prod%0d_done c=%0d got %b exp %b", i, c, done, (c == 9)); end
        if (c < 9) begin
          checks++;
          if (product !== last_prod) begin errors++; $display("FAIL prod%0d_hold c=%0d got %h exp %h", i, c, product, last_prod); end
        end
        if (done === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL prod%0d_unexpected_done got done exp none", i); end
          else begin
            exp = exp_q.pop_front();
            if (product !== exp) begin errors++; $display("FAIL prod%0d_value got %h exp %h", i, product, exp); end
            last_prod = exp;
          end
        end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL prod%0d_missing_done got %0d pending exp 0", i, exp_q.size()); exp_q.delete(); end
    end
  endtask

  task automatic test_ignore_start();
    int          ndone;
    logic [15:0] exp;
    ndone = 0;
    start = 1'b1; a = 8'h12; b = 8'h34;
    exp_q.push_back(16'h03A8);
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = (c == 3 || c == 9);
      a = 8'hFF; b = 8'hFF;
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (c != 9) begin errors++; $display("FAIL ign_done_cycle got %0d exp 9", c); end
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          checks++;
          if (product !== exp) begin errors++; $display("FAIL ign_value got %h exp %h", product, exp); end
          last_prod = exp;
        end
      end
      if (c >= 11) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy c=%0d got %b exp 0", c, busy); end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", ndone); end
    checks++;
    if (product !== 16'h03A8) begin errors++; $display("FAIL ign_final got %h exp 03a8", product); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int          ndone;
    logic [15:0] exp;
    start = 1'b1; a = 8'hC8; b = 8'h03;
    exp_q.push_back(16'h0258);
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    last_prod = 16'h0000;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", done); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL rstmid_product got %h exp 0000", product); end
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL rstmid_stray_done got %0d exp 0", ndone); end
    start = 1'b1; a = 8'h07; b = 8'h09;
    exp_q.push_back(16'h003F);
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (c != 9) begin errors++; $display("FAIL rstmid_latency got %0d exp 9", c); end
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          checks++;
          if (product !== exp) begin errors++; $display("FAIL rstmid_value got %h exp %h", product, exp); end
          last_prod = exp;
        end
      end
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL rstmid_done_count got %0d exp 1", ndone); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int          ndone;
    logic [15:0] exp;
    ndone = 0;
    start = 1'b1; a = 8'h80; b = 8'h02;
    exp_q.push_back(16'h0100);
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (c == 10 || c == 20) exp_q.push_back(16'h0100);
      checks++;
      if (done !== (c == 9 || c == 19 || c == 29)) begin
        errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done, (c == 9 || c == 19 || c == 29));
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected_done c=%0d got done exp none", c); end
        else begin
          exp = exp_q.pop_front();
          if (product !== exp) begin errors++; $display("FAIL b2b_value c=%0d got %h exp %h", c, product, exp); end
          last_prod = exp;
        end
      end
      if (c == 29) start = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_final_busy got %b exp 0", busy); end
    checks++;
    if (ndone != 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", ndone); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    tick();
    test_reset();
    test_products();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
